// File: rtl/mem_bus_resp_pkg.sv
// Shared types and default constants for the 6502C bus responder.
package mem_bus_resp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_HOLD = 3'd2,
      WR_CAP  = 3'd3,
      WR_REQ  = 3'd4
   } state_t;

   localparam int         DEF_ACK_TIMEOUT  = 255;
   localparam logic [7:0] DEF_DEFAULT_DATA = 8'hFF;

endpackage

// File: rtl/phi2_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall detect.
// Also suitable for the interrupt-line synchronizers.
module phi2_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic phi2_s,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_dly  <= 1'b0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign phi2_s = r_sync;
   assign rise   = r_sync & ~r_dly;
   assign fall   = ~r_sync & r_dly;

endmodule

// File: rtl/mem_bus_responder.sv
// Slave for the 6502C external bus: turns CPU cycles into memory req/ack
// transactions, stretches reads with RDY and counts opcode fetches.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a phi2 rise to decode a new CPU cycle
//   RD_REQ  | read request outstanding, RDY held low
//   RD_HOLD | read data in buffer, driven onto extDB while phi2 is high
//   WR_CAP  | write decoded, waiting for phi2 fall to capture extDB_in
//   WR_REQ  | write request outstanding, next CPU cycle may be parked
module mem_bus_responder
   import mem_bus_resp_pkg::*;
#(
   parameter int         ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
   parameter logic [7:0] DEFAULT_DATA = DEF_DEFAULT_DATA
) (
   input  logic        fastClk,
   input  logic        RES_L,
   input  logic        phi2,
   input  logic [7:0]  extABH,
   input  logic [7:0]  extABL,
   input  logic        RW,
   input  logic        SYNC,
   input  logic [7:0]  extDB_in,
   output logic [7:0]  extDB_out,
   output logic        extDB_oe,
   output logic        RDY,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic [15:0] fetch_count
);

   localparam int            TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TC = TW'(ACK_TIMEOUT - 1);

   logic w_phi2_s, w_rise, w_fall;

   phi2_edge_sync u_phi2_sync (
      .clk      (fastClk),
      .rst_n    (RES_L),
      .async_in (phi2),
      .phi2_s   (w_phi2_s),
      .rise     (w_rise),
      .fall     (w_fall)
   );

   state_t        r_state, w_state_nx;
   logic          r_mem_req, w_mem_req_nx;
   logic          r_mem_we, w_mem_we_nx;
   logic [15:0]   r_mem_addr, w_mem_addr_nx;
   logic [7:0]    r_mem_wdata, w_mem_wdata_nx;
   logic [7:0]    r_extdb, w_extdb_nx;
   logic          r_oe, w_oe_nx;
   logic          r_bus_err, w_bus_err_nx;
   logic [15:0]   r_fetch_count, w_fetch_nx;
   logic [7:0]    r_rd_buf, w_rd_buf_nx;
   logic [15:0]   r_rd_tag, w_rd_tag_nx;
   logic          r_rd_valid, w_rd_valid_nx;
   logic          r_pend_valid, w_pend_valid_nx;
   logic [15:0]   r_pend_addr, w_pend_addr_nx;
   logic          r_pend_rw, w_pend_rw_nx;
   logic          r_pend_fell, w_pend_fell_nx;
   logic [TW-1:0] r_tmo_cnt, w_tmo_nx;

   logic          w_start, w_st_rw, w_st_fell;
   logic [15:0]   w_st_addr;
   logic [15:0]   w_ab;
   logic          w_done_ack, w_done_tmo, w_done;

   assign w_ab       = {extABH, extABL};
   assign w_done_ack = r_mem_req & mem_ack;
   assign w_done_tmo = r_mem_req & ~mem_ack & (r_tmo_cnt == TC);
   assign w_done     = w_done_ack | w_done_tmo;

   always_ff @(posedge fastClk or negedge RES_L) begin
      if (!RES_L) begin
         r_state       <= IDLE;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_extdb       <= '0;
         r_oe          <= 1'b0;
         r_bus_err     <= 1'b0;
         r_fetch_count <= '0;
         r_rd_buf      <= '0;
         r_rd_tag      <= '0;
         r_rd_valid    <= 1'b0;
         r_pend_valid  <= 1'b0;
         r_pend_addr   <= '0;
         r_pend_rw     <= 1'b0;
         r_pend_fell   <= 1'b0;
         r_tmo_cnt     <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_mem_req     <= w_mem_req_nx;
         r_mem_we      <= w_mem_we_nx;
         r_mem_addr    <= w_mem_addr_nx;
         r_mem_wdata   <= w_mem_wdata_nx;
         r_extdb       <= w_extdb_nx;
         r_oe          <= w_oe_nx;
         r_bus_err     <= w_bus_err_nx;
         r_fetch_count <= w_fetch_nx;
         r_rd_buf      <= w_rd_buf_nx;
         r_rd_tag      <= w_rd_tag_nx;
         r_rd_valid    <= w_rd_valid_nx;
         r_pend_valid  <= w_pend_valid_nx;
         r_pend_addr   <= w_pend_addr_nx;
         r_pend_rw     <= w_pend_rw_nx;
         r_pend_fell   <= w_pend_fell_nx;
         r_tmo_cnt     <= w_tmo_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_mem_req_nx    = r_mem_req;
      w_mem_we_nx     = r_mem_we;
      w_mem_addr_nx   = r_mem_addr;
      w_mem_wdata_nx  = r_mem_wdata;
      w_extdb_nx      = r_extdb;
      w_rd_buf_nx     = r_rd_buf;
      w_rd_tag_nx     = r_rd_tag;
      w_rd_valid_nx   = r_rd_valid;
      w_pend_valid_nx = r_pend_valid;
      w_pend_addr_nx  = r_pend_addr;
      w_pend_rw_nx    = r_pend_rw;
      w_pend_fell_nx  = r_pend_fell;
      w_bus_err_nx    = w_done_tmo;
      w_fetch_nx      = (w_rise && SYNC) ? r_fetch_count + 16'd1 : r_fetch_count;
      w_tmo_nx        = (r_mem_req && !w_done) ? r_tmo_cnt + 1'b1 : '0;
      w_start         = 1'b0;
      w_st_addr       = w_ab;
      w_st_rw         = RW;
      w_st_fell       = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_rise) w_start = 1'b1;
         end
         RD_REQ: begin
            if (w_done) begin
               w_rd_buf_nx   = w_done_ack ? mem_rdata : DEFAULT_DATA;
               w_rd_tag_nx   = r_mem_addr;
               w_rd_valid_nx = 1'b1;
               w_mem_req_nx  = 1'b0;
               w_state_nx    = w_phi2_s ? RD_HOLD : IDLE;
            end
         end
         RD_HOLD: begin
            if (w_fall) w_state_nx = IDLE;
         end
         WR_CAP: begin
            if (w_fall) begin
               w_mem_wdata_nx = extDB_in;
               w_mem_req_nx   = 1'b1;
               w_mem_we_nx    = 1'b1;
               w_state_nx     = WR_REQ;
            end
         end
         WR_REQ: begin
            if (w_done) begin
               w_mem_req_nx = 1'b0;
               w_state_nx   = IDLE;
               if (r_pend_valid) begin
                  w_pend_valid_nx = 1'b0;
                  w_pend_fell_nx  = 1'b0;
                  w_start         = 1'b1;
                  w_st_addr       = r_pend_addr;
                  w_st_rw         = r_pend_rw;
                  w_st_fell       = r_pend_fell | w_fall;
               end else if (w_rise) begin
                  // rise coincides with completion: decode it directly
                  w_start = 1'b1;
               end
            end else if (w_rise && !r_pend_valid) begin
               w_pend_valid_nx = 1'b1;
               w_pend_addr_nx  = w_ab;
               w_pend_rw_nx    = RW;
               w_pend_fell_nx  = 1'b0;
            end else if (w_fall && r_pend_valid) begin
               w_pend_fell_nx = 1'b1;
            end
         end
         default: w_state_nx = IDLE;
      endcase

      if (w_start) begin
         if (w_st_rw && r_rd_valid && (w_st_addr == r_rd_tag)) begin
            w_state_nx = RD_HOLD;
         end else if (w_st_rw) begin
            w_state_nx    = RD_REQ;
            w_mem_req_nx  = 1'b1;
            w_mem_we_nx   = 1'b0;
            w_mem_addr_nx = w_st_addr;
            w_rd_valid_nx = 1'b0;
         end else begin
            w_mem_addr_nx = w_st_addr;
            w_rd_valid_nx = 1'b0;
            if (w_st_fell) begin
               w_mem_wdata_nx = extDB_in;
               w_mem_req_nx   = 1'b1;
               w_mem_we_nx    = 1'b1;
               w_state_nx     = WR_REQ;
            end else begin
               w_state_nx = WR_CAP;
            end
         end
      end

      if (w_state_nx == RD_HOLD) w_extdb_nx = w_rd_buf_nx;
      w_oe_nx = (w_state_nx == RD_HOLD) && w_phi2_s;
   end

   assign RDY         = ~((r_state == RD_REQ) | (r_pend_valid & r_pend_rw));
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign extDB_out   = r_extdb;
   assign extDB_oe    = r_oe;
   assign bus_err     = r_bus_err;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: CPU cycle driver, memory responder with a
// request scoreboard, and a read-data scoreboard.
module tb_mem_bus_responder;

   localparam int TMO = 255;

   logic        fastClk;
   logic        RES_L;
   logic        phi2;
   logic [7:0]  extABH, extABL;
   logic        RW, SYNC;
   logic [7:0]  extDB_in;
   logic [7:0]  extDB_out;
   logic        extDB_oe, RDY;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic [15:0] fetch_count;

   mem_bus_responder dut (
      .fastClk     (fastClk),
      .RES_L       (RES_L),
      .phi2        (phi2),
      .extABH      (extABH),
      .extABL      (extABL),
      .RW          (RW),
      .SYNC        (SYNC),
      .extDB_in    (extDB_in),
      .extDB_out   (extDB_out),
      .extDB_oe    (extDB_oe),
      .RDY         (RDY),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .bus_err     (bus_err),
      .fetch_count (fetch_count)
   );

   // delay >= 0: ack after that many cycles; -1: expect timeout; -2: abandoned
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          delay;
   } req_t;

   req_t       exp_req_q[$];
   logic [7:0] exp_rd_q[$];
   logic [7:0] mem_model [0:65535];
   int         n_vec = 0;
   int         n_bad = 0;
   int         n_req = 0;
   int         n_berr = 0;
   int         late_ack_req = 0;

   initial begin
      fastClk = 1'b0;
      forever #5 fastClk = ~fastClk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_req(input logic we, input logic [15:0] a, input logic [7:0] wd, input int dly);
      req_t e;
      e.we = we; e.addr = a; e.wdata = wd; e.delay = dly;
      exp_req_q.push_back(e);
   endtask

   // memory side: detect each new request, score it, then ack or wait
   initial begin : responder
      logic prev_req, prev_ack, ok;
      int   late_done, n;
      req_t e;
      prev_req = 1'b0; prev_ack = 1'b0; late_done = 0;
      mem_ack = 1'b0; mem_rdata = 8'h00;
      for (int i = 0; i < 65536; i++) mem_model[i] = 8'(i) ^ 8'(i >> 8);
      mem_model[16'hFFFC] = 8'h34;
      forever begin
         @(negedge fastClk);
         prev_ack = mem_ack;
         mem_ack  = 1'b0;
         if (late_ack_req != late_done) begin
            late_done++;
            mem_ack   = 1'b1;
            mem_rdata = 8'h77;
         end else if (RES_L === 1'b1 && mem_req === 1'b1 && (!prev_req || prev_ack)) begin
            n_req++;
            check_eq("req_expected", 32'(exp_req_q.size() != 0), 1);
            if (exp_req_q.size() != 0) begin
               e = exp_req_q.pop_front();
               check_eq("req_we", mem_we, e.we);
               check_eq("req_addr", mem_addr, e.addr);
               if (e.we) check_eq("req_wdata", mem_wdata, e.wdata);
               ok = 1'b1; n = 0;
               if (e.delay >= 0) begin
                  repeat (e.delay) begin
                     @(negedge fastClk);
                     if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_we !== e.we ||
                         (e.we && mem_wdata !== e.wdata)) ok = 1'b0;
                  end
                  check_eq("req_stable", ok, 1);
                  mem_ack   = 1'b1;
                  mem_rdata = mem_model[e.addr];
                  if (e.we) mem_model[e.addr] = e.wdata;
               end else begin
                  while (mem_req === 1'b1 && RES_L === 1'b1 && n < 1000) begin
                     @(negedge fastClk);
                     n++;
                  end
                  if (e.delay == -1) begin
                     check_eq("tmo_cycles", n, TMO);
                     check_eq("tmo_bus_err", bus_err, 1);
                  end
               end
            end
         end
         prev_req = mem_req;
      end
   end

   initial begin : berr_mon
      forever begin
         @(negedge fastClk);
         if (bus_err === 1'b1) n_berr++;
      end
   end

   task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic sync,
                            input logic [7:0] wd, output logic rdy, output logic oe,
                            output logic [7:0] d);
      @(negedge fastClk);
      phi2 = 1'b0;
      extABH = a[15:8]; extABL = a[7:0]; RW = rw; SYNC = sync;
      repeat (6) @(negedge fastClk);
      phi2 = 1'b1;
      extDB_in = rw ? 8'h00 : wd;
      repeat (8) @(negedge fastClk);
      rdy = RDY; oe = extDB_oe; d = extDB_out;
      phi2 = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [15:0] a, input logic sync,
                           input logic [7:0] ed, input int max_tries, output logic first_rdy);
      logic       rdy, oe;
      logic [7:0] d;
      int         tries;
      exp_rd_q.push_back(ed);
      tries = 0; first_rdy = 1'b0; rdy = 1'b0;
      do begin
         cpu_cycle(a, 1'b1, sync, 8'h00, rdy, oe, d);
         if (tries == 0) first_rdy = rdy;
         tries++;
      end while (!rdy && tries < max_tries);
      check_eq({tag, "_done"}, rdy, 1);
      check_eq({tag, "_oe"}, oe, 1);
      check_eq({tag, "_data"}, d, exp_rd_q.pop_front());
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rdy"}, RDY, 1);
      check_eq({tag, "_req"}, mem_req, 0);
      check_eq({tag, "_we"}, mem_we, 0);
      check_eq({tag, "_addr"}, mem_addr, 0);
      check_eq({tag, "_wdata"}, mem_wdata, 0);
      check_eq({tag, "_dbout"}, extDB_out, 0);
      check_eq({tag, "_oe"}, extDB_oe, 0);
      check_eq({tag, "_berr"}, bus_err, 0);
      check_eq({tag, "_fetch"}, fetch_count, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic rdy, oe, first;
      logic [7:0] d;
      int b0, r0;
      RES_L = 1'b0; phi2 = 1'b0; extABH = 8'h00; extABL = 8'h00;
      RW = 1'b1; SYNC = 1'b0; extDB_in = 8'h00;
      repeat (3) @(negedge fastClk);
      check_reset_vals("reset");
      RES_L = 1'b1;
      repeat (3) @(negedge fastClk);

      // read miss with ack five cycles after the request
      b0 = n_berr; r0 = n_req;
      push_req(1'b0, 16'hFFFC, 8'h00, 5);
      cpu_read("miss", 16'hFFFC, 1'b0, 8'h34, 10, first);
      check_eq("miss_rdy_stall", first, 0);
      check_eq("miss_reqs", n_req - r0, 1);
      check_eq("miss_no_berr", n_berr - b0, 0);

      // ack withheld over several phi2 periods, then a buffer hit
      r0 = n_req;
      push_req(1'b0, 16'h4000, 8'h00, 40);
      cpu_read("stall", 16'h4000, 1'b0, mem_model[16'h4000], 10, first);
      check_eq("stall_rdy_low", first, 0);
      check_eq("stall_one_req", n_req - r0, 1);
      cpu_read("hit", 16'h4000, 1'b0, mem_model[16'h4000], 2, first);
      check_eq("hit_rdy", first, 1);
      check_eq("hit_no_req", n_req - r0, 1);

      // write, then a read parked behind the slow write ack
      push_req(1'b1, 16'h0200, 8'hA5, 30);
      cpu_cycle(16'h0200, 1'b0, 1'b0, 8'hA5, rdy, oe, d);
      check_eq("wr_rdy", rdy, 1);
      push_req(1'b0, 16'h0201, 8'h00, 3);
      cpu_read("wr_rd", 16'h0201, 1'b0, mem_model[16'h0201], 10, first);
      check_eq("wr_rd_stall", first, 0);
      push_req(1'b0, 16'h0200, 8'h00, 2);
      cpu_read("rd_back", 16'h0200, 1'b0, 8'hA5, 10, first);

      // timeout: never acked
      b0 = n_berr; r0 = n_req;
      push_req(1'b0, 16'h1234, 8'h00, -1);
      cpu_read("tmo", 16'h1234, 1'b0, 8'hFF, 40, first);
      check_eq("tmo_one_pulse", n_berr - b0, 1);
      cpu_read("tmo_hit", 16'h1234, 1'b1, 8'hFF, 2, first);
      check_eq("tmo_hit_rdy", first, 1);
      check_eq("tmo_reqs", n_req - r0, 1);
      check_eq("fetch_one", fetch_count, 16'd1);

      // fetch counter wrap, preloaded near the top
      @(negedge fastClk);
      force dut.r_fetch_count = 16'hFFFE;
      @(negedge fastClk);
      release dut.r_fetch_count;
      cpu_read("f0", 16'h1234, 1'b0, 8'hFF, 2, first);
      check_eq("fetch_nosync", fetch_count, 16'hFFFE);
      cpu_read("f1", 16'h1234, 1'b1, 8'hFF, 2, first);
      check_eq("fetch_ffff", fetch_count, 16'hFFFF);
      cpu_read("f2", 16'h1234, 1'b1, 8'hFF, 2, first);
      check_eq("fetch_wrap", fetch_count, 16'h0000);
      cpu_read("f3", 16'h1234, 1'b0, 8'hFF, 2, first);
      check_eq("fetch_hold", fetch_count, 16'h0000);

      // reset in the middle of an outstanding read, then a late ack
      push_req(1'b0, 16'h0300, 8'h00, -2);
      @(negedge fastClk);
      extABH = 8'h03; extABL = 8'h00; RW = 1'b1; SYNC = 1'b0;
      repeat (6) @(negedge fastClk);
      phi2 = 1'b1;
      repeat (6) @(negedge fastClk);
      check_eq("rst_pre_req", mem_req, 1);
      check_eq("rst_pre_rdy", RDY, 0);
      RES_L = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      @(negedge fastClk);
      phi2 = 1'b0;
      repeat (3) @(negedge fastClk);
      RES_L = 1'b1;
      repeat (2) @(negedge fastClk);
      late_ack_req++;
      repeat (4) @(negedge fastClk);
      check_eq("late_ack_req", mem_req, 0);
      check_eq("late_ack_rdy", RDY, 1);
      r0 = n_req;
      push_req(1'b0, 16'h0300, 8'h00, 2);
      cpu_read("post_rst", 16'h0300, 1'b0, mem_model[16'h0300], 10, first);
      check_eq("post_rst_miss", n_req - r0, 1);

      repeat (5) @(negedge fastClk);
      check_eq("req_q_empty", exp_req_q.size(), 0);
      check_eq("rd_q_empty", exp_rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Bus-side responder for the 6502C external bus. It is the slave at the far end of the CPU's extABH/extABL, RW, extDB, phi2 and RDY pins. It decodes each CPU bus cycle, turns it into a single request/acknowledge transaction on the board memory port, and returns read data onto extDB during phi2. While a read is outstanding it holds RDY low to stretch the CPU cycle. It also counts opcode fetches (SYNC cycles) for the debug display.

## Interface
Parameters:
- ACK_TIMEOUT, 255: fastClk cycles to wait for mem_ack before abandoning a request.
- DEFAULT_DATA, 8'hFF: read data returned when a read request times out.

Ports:
- fastClk  in  1  system clock, at least 8x the phi2 frequency. The only clock in the block.
- RES_L  in  1  reset, asynchronous, active-low.
- phi2  in  1  CPU phi2_out, asynchronous to fastClk. Passed through a 2-flop synchronizer.
- extABH, extABL  in  8 each  CPU address bus.
- RW  in  1  CPU read/write: 1 = read, 0 = write.
- SYNC  in  1  CPU opcode-fetch indicator.
- extDB_in  in  8  CPU write data.
- extDB_out  out  8  read data to the CPU.
- extDB_oe  out  1  drive enable for extDB. The top level instantiates the tristate.
- RDY  out  1  CPU ready. 0 stalls the CPU.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write request.
- mem_addr  out  16  {extABH, extABL} as captured.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge. Ignored while mem_req = 0.
- bus_err  out  1  one-cycle pulse on request timeout.
- fetch_count  out  16  number of SYNC cycles seen.

## Operation
- phi2 synchronization:
  - phi2_s is the second synchronizer flop; phi2_d is phi2_s delayed one cycle.
  - rise = phi2_s & ~phi2_d.
  - fall = ~phi2_s & phi2_d.
- Address, RW and SYNC are sampled on the cycle where rise = 1.
- On a rise with SYNC = 1, fetch_count increments. It wraps from 16'hFFFF to 0.
- Read buffer: rd_buf (8 bits), rd_tag (16 bits), rd_valid (1 bit). rd_valid is cleared by any accepted write or by a read miss.
- FSM states:
  - IDLE:
    - rise with RW=1 and {AB} = rd_tag and rd_valid → RD_HOLD. This is a buffer hit and issues no request.
    - rise with RW=1 otherwise → RD_REQ. mem_req=1, mem_we=0, rd_valid=0.
    - rise with RW=0 → WR_CAP.
  - RD_REQ:
    - RDY=0.
    - On mem_ack: rd_buf=mem_rdata, rd_tag=mem_addr, rd_valid=1, mem_req=0. Go to RD_HOLD if phi2_s=1, else IDLE.
    - Further rises while in RD_REQ are the CPU repeating the same stalled cycle and are ignored.
  - RD_HOLD:
    - extDB_out=rd_buf.
    - extDB_oe = phi2_s.
    - On fall → IDLE.
  - WR_CAP:
    - On fall: mem_wdata=extDB_in, mem_req=1, mem_we=1 → WR_REQ.
  - WR_REQ:
    - A rise in this state latches pend_addr, pend_rw and sets pend_valid.
    - On mem_ack: mem_req=0. If pend_valid, clear it and process pend_* exactly as an IDLE rise; otherwise → IDLE.
- RDY = 0 when state = RD_REQ, or when pend_valid=1 and pend_rw=1. RDY = 1 otherwise.
- A pending write while in WR_REQ is handled through WR_CAP. If its fall has already occurred, extDB_in is captured immediately.
- Timeout: a counter runs while mem_req=1 and clears when mem_req=0. When it reaches ACK_TIMEOUT:
  - mem_req=0 and bus_err pulses.
  - A read loads rd_buf=DEFAULT_DATA and sets rd_valid=1, then proceeds as on ack.
  - A write proceeds as on ack.
- Reset values:
  - state=IDLE, RDY=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, extDB_out=0, extDB_oe=0, bus_err=0, fetch_count=0.
  - rd_valid=0, pend_valid=0, timeout counter=0.
- Reset asserted mid-transaction abandons the request. A late mem_ack arriving after reset is ignored.

## Timing
- Rise detection happens 2–3 fastClk edges after phi2 goes high.
- mem_req, and RDY=0 for reads, are registered on the edge following the rise cycle.
- mem_ack in cycle N clears mem_req and sets RDY=1 on edge N+1. extDB_oe follows on that same edge if phi2_s=1.
- A buffer hit drives extDB_oe on the edge after rise. No RDY stall occurs.
- extDB_oe deasserts on the edge after fall is detected.
- Write requests issue on the edge after fall. mem_wdata is stable with mem_req.
- mem_addr, mem_we and mem_wdata are stable for the whole interval in which mem_req=1.
- Timeout fires exactly ACK_TIMEOUT cycles after mem_req rises.

## Structure
- Package mem_bus_resp_pkg holds:
  - state enum: IDLE, RD_REQ, RD_HOLD, WR_CAP, WR_REQ.
  - default ACK_TIMEOUT and DEFAULT_DATA constants.
- Sub-module phi2_edge_sync contains the 2-flop synchronizer plus edge detect, with outputs phi2_s, rise and fall. It is reusable for the interrupt-line synchronizers.
- The FSM, read buffer, pending slot, timeout counter and fetch counter live in the top module.

## Test plan
- Read miss:
  - Stimulus: RW=1, AB=16'hFFFC, mem_ack with 8'h34 five cycles after mem_req.
  - Required: mem_addr=16'hFFFC, mem_we=0; RDY=0 until the ack; extDB_out=8'h34 with oe high during phi2; bus_err=0.
- Stalled repeat:
  - Stimulus: ack withheld across two phi2 periods, then an ack.
  - Required: exactly one mem_req; the following phi2 rise at the same address hits, with no new request and RDY=1.
- Write then read:
  - Stimulus: RW=0, AB=16'h0200, extDB_in=8'hA5; the next cycle is a read from 16'h0201 while the write ack is delayed.
  - Required: write request carries 8'hA5 after the fall; RDY=0 until the write acks; read request for 16'h0201 follows.
- Timeout:
  - Stimulus: a read with mem_ack never asserted.
  - Required: after 255 cycles, a single bus_err pulse; extDB_out=8'hFF; RDY returns to 1.
- SYNC counting:
  - Stimulus: fetch_count preloaded via 65535 SYNC cycles, then one more SYNC cycle.
  - Required: fetch_count wraps to 0; non-SYNC cycles do not increment it.
- Reset:
  - Stimulus: RES_L pulsed low in RD_REQ, then a late mem_ack.
  - Required: all outputs at their reset values immediately; the ack is ignored; rd_valid=0.
